// File: rtl/gmsk_burst_formatter.sv
// GSM normal-burst formatter feeding the GMSK modulator one symbol per strobe edge.
// Burst layout: TAILH(3) DATA1(57) STL1(1) TRAIN(26) STL2(1) DATA2(57) TAILT(3) GUARD(GUARD_SYMS).
// Payload handshake: a payload bit moves from the source into the one-entry buffer
// in every cycle where data_valid and data_ready are both high at the clock edge;
// data_ready is registered and never depends combinationally on data_valid.
// GUARD_SYMS is expected in 1..15.
module gmsk_burst_formatter #(
    parameter int unsigned GUARD_SYMS  = 8,
    parameter bit          DIFF_ENCODE = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] tsc_sel,
    input  logic [1:0] steal_flags,
    input  logic       data_bit,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic       symbol_input_strobe,
    output logic       current_symbol_o,
    output logic       burst_active,
    output logic       burst_done,
    output logic       underrun,
    output logic [3:0] dbg_state_o
);

    localparam logic [7:0] PAYLOAD_BITS = 8'd114;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_TAILH = 4'd1,
        ST_DATA1 = 4'd2,
        ST_STL1  = 4'd3,
        ST_TRAIN = 4'd4,
        ST_STL2  = 4'd5,
        ST_DATA2 = 4'd6,
        ST_TAILT = 4'd7,
        ST_GUARD = 4'd8
    } state_t;

    // Normal-burst training sequences, transmitted MSB first.
    function automatic logic [25:0] tsc_word(input logic [2:0] sel);
        logic [25:0] w;
        case (sel)
            3'd0:    w = 26'h0970897;
            3'd1:    w = 26'h0B778B7;
            3'd2:    w = 26'h10EE90E;
            3'd3:    w = 26'h11ED11E;
            3'd4:    w = 26'h06B906B;
            3'd5:    w = 26'h13AC13A;
            3'd6:    w = 26'h29F629F;
            default: w = 26'h3BC4BBC;
        endcase
        return w;
    endfunction

    // Field length minus one: the value the field counter loads on entry.
    function automatic logic [5:0] field_last(input state_t st);
        logic [5:0] n;
        case (st)
            ST_TAILH, ST_TAILT: n = 6'd2;
            ST_DATA1, ST_DATA2: n = 6'd56;
            ST_TRAIN:           n = 6'd25;
            ST_GUARD:           n = 6'(GUARD_SYMS - 1);
            default:            n = 6'd0;
        endcase
        return n;
    endfunction

    function automatic state_t field_next(input state_t st);
        state_t n;
        case (st)
            ST_TAILH: n = ST_DATA1;
            ST_DATA1: n = ST_STL1;
            ST_STL1:  n = ST_TRAIN;
            ST_TRAIN: n = ST_STL2;
            ST_STL2:  n = ST_DATA2;
            ST_DATA2: n = ST_TAILT;
            ST_TAILT: n = ST_GUARD;
            default:  n = ST_IDLE;
        endcase
        return n;
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        strb_q;
    logic [2:0]  tsc_q, tsc_d;
    logic [1:0]  steal_q, steal_d;
    logic        prev_raw_q, prev_raw_d;
    logic        sym_q, sym_d;
    logic        active_q, active_d;
    logic        done_q, done_d;
    logic        underrun_q, underrun_d;
    logic        buf_q, buf_d;
    logic        full_q, full_d;
    logic [6:0]  acc_q, acc_d;
    logic        ready_q, ready_d;

    logic        edge_w;
    logic        issue_w;
    logic        start_acc_w;
    logic        pop_w;
    logic        pop_empty_w;
    logic        xfer_w;
    logic        raw_w;
    logic [25:0] train_word_w;
    logic [7:0]  acc_sum_w;

    // Only a rising strobe edge in an active field consumes a symbol.
    assign edge_w       = symbol_input_strobe & ~strb_q;
    assign issue_w      = edge_w & (state_q != ST_IDLE);
    assign start_acc_w  = start & (state_q == ST_IDLE);
    assign pop_w        = issue_w & ((state_q == ST_DATA1) | (state_q == ST_DATA2));
    assign pop_empty_w  = pop_w & ~full_q;
    assign xfer_w       = data_valid & ready_q;
    assign train_word_w = tsc_word(tsc_q);

    // FSM register: current field and position inside it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: walk the fields, one counter step per consumed symbol.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d = ST_TAILH;
                cnt_d   = field_last(ST_TAILH);
            end
        end else if (issue_w) begin
            if (cnt_q == 6'd0) begin
                state_d = field_next(state_q);
                cnt_d   = field_last(field_next(state_q));
            end else begin
                cnt_d = cnt_q - 6'd1;
            end
        end
    end

    // Raw field bit for the symbol being issued; an empty payload slot sends 0.
    always_comb begin
        raw_w = 1'b1;
        case (state_q)
            ST_TAILH, ST_TAILT: raw_w = 1'b0;
            ST_DATA1, ST_DATA2: raw_w = full_q & buf_q;
            ST_STL1:            raw_w = steal_q[1];
            ST_STL2:            raw_w = steal_q[0];
            ST_TRAIN:           raw_w = train_word_w[cnt_q[4:0]];
            default:            raw_w = 1'b1;
        endcase
    end

    // Datapath next state: symbol encoding, payload buffer, counters and flags.
    always_comb begin
        tsc_d      = tsc_q;
        steal_d    = steal_q;
        prev_raw_d = prev_raw_q;
        sym_d      = sym_q;
        underrun_d = underrun_q;
        buf_d      = buf_q;
        full_d     = full_q;
        acc_d      = acc_q;
        done_d     = issue_w & (state_q == ST_GUARD) & (cnt_q == 6'd0);
        active_d   = (state_d != ST_IDLE);
        acc_sum_w  = {1'b0, acc_q} + {7'd0, xfer_w} + {7'd0, pop_empty_w};

        if (start_acc_w) begin
            tsc_d      = tsc_sel;
            steal_d    = steal_flags;
            prev_raw_d = 1'b1;
            underrun_d = 1'b0;
            full_d     = 1'b0;
            acc_d      = 7'd0;
        end else begin
            if (issue_w) begin
                if (state_q == ST_GUARD) begin
                    sym_d = 1'b1;
                end else begin
                    sym_d      = DIFF_ENCODE ? (raw_w ^ prev_raw_q) : raw_w;
                    prev_raw_d = raw_w;
                end
            end
            if (pop_empty_w) begin
                underrun_d = 1'b1;
            end
            // Pop sees the old contents; a same-cycle fill lands after the pop.
            if (pop_w) begin
                full_d = 1'b0;
            end
            if (xfer_w) begin
                buf_d  = data_bit;
                full_d = 1'b1;
            end
            acc_d = (acc_sum_w >= PAYLOAD_BITS) ? PAYLOAD_BITS[6:0] : acc_sum_w[6:0];
        end

        if (state_d == ST_IDLE) begin
            sym_d = 1'b1;
        end
        ready_d = active_d & ~full_d & ({1'b0, acc_d} < PAYLOAD_BITS);
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            strb_q     <= 1'b0;
            tsc_q      <= 3'd0;
            steal_q    <= 2'd0;
            prev_raw_q <= 1'b1;
            sym_q      <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            buf_q      <= 1'b0;
            full_q     <= 1'b0;
            acc_q      <= 7'd0;
            ready_q    <= 1'b0;
        end else begin
            strb_q     <= symbol_input_strobe;
            tsc_q      <= tsc_d;
            steal_q    <= steal_d;
            prev_raw_q <= prev_raw_d;
            sym_q      <= sym_d;
            active_q   <= active_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
            buf_q      <= buf_d;
            full_q     <= full_d;
            acc_q      <= acc_d;
            ready_q    <= ready_d;
        end
    end

    assign data_ready       = ready_q;
    assign current_symbol_o = sym_q;
    assign burst_active     = active_q;
    assign burst_done       = done_q;
    assign underrun         = underrun_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_gmsk_burst_formatter.sv
// Directed bench for gmsk_burst_formatter: one plain and one differential instance share stimulus.
module tb_gmsk_burst_formatter;

    localparam int NSYM = 156;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] tsc_sel;
    logic [1:0] steal_flags;
    logic       data_bit;
    logic       data_valid;
    logic       symbol_input_strobe;

    logic       rdy0, sym0, act0, done0, und0;
    logic       rdy1, sym1, act1, done1, und1;
    logic [3:0] st0, st1;

    int checks = 0;
    int errors = 0;
    int pay_idx;
    int xfer_cnt;
    int done_cnt;

    bit          pay [0:113];
    logic [25:0] tsc_tab [0:7];
    logic        exp_raw [0:NSYM-1];
    logic        exp_dif [0:NSYM-1];

    // Clock and reset block.
    always #5 clock = ~clock;

    gmsk_burst_formatter #(.GUARD_SYMS(8), .DIFF_ENCODE(1'b0)) dut0 (
        .clock(clock), .reset(reset), .start(start), .tsc_sel(tsc_sel),
        .steal_flags(steal_flags), .data_bit(data_bit), .data_valid(data_valid),
        .data_ready(rdy0), .symbol_input_strobe(symbol_input_strobe),
        .current_symbol_o(sym0), .burst_active(act0), .burst_done(done0),
        .underrun(und0), .dbg_state_o(st0)
    );

    gmsk_burst_formatter #(.GUARD_SYMS(8), .DIFF_ENCODE(1'b1)) dut1 (
        .clock(clock), .reset(reset), .start(start), .tsc_sel(tsc_sel),
        .steal_flags(steal_flags), .data_bit(data_bit), .data_valid(data_valid),
        .data_ready(rdy1), .symbol_input_strobe(symbol_input_strobe),
        .current_symbol_o(sym1), .burst_active(act1), .burst_done(done1),
        .underrun(und1), .dbg_state_o(st1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: inputs change 1 time unit after the edge, outputs are read there too.
    task automatic tick();
        logic xfer;
        xfer = data_valid & rdy0;
        @(posedge clock);
        #1;
        if (done0) done_cnt++;
        if (xfer) begin
            xfer_cnt++;
            if (pay_idx < 113) pay_idx++;
            data_bit = pay[pay_idx];
        end
    endtask

    // Expected symbol stream for one burst from the field layout.
    task automatic build_model(input logic [2:0] tsc, input logic [1:0] stl, input bit starve);
        logic [25:0] tw;
        logic        r;
        logic        prev;
        tw = tsc_tab[tsc];
        for (int i = 0; i < NSYM; i++) begin
            if (i < 3)        r = 1'b0;
            else if (i < 60)  r = starve ? 1'b0 : pay[i-3];
            else if (i == 60) r = stl[1];
            else if (i < 87)  r = tw[25-(i-61)];
            else if (i == 87) r = stl[0];
            else if (i < 145) r = starve ? 1'b0 : pay[i-31];
            else if (i < 148) r = 1'b0;
            else              r = 1'b1;
            exp_raw[i] = r;
        end
        prev = 1'b1;
        for (int i = 0; i < NSYM; i++) begin
            if (i < 148) begin
                exp_dif[i] = exp_raw[i] ^ prev;
                prev = exp_raw[i];
            end else begin
                exp_dif[i] = 1'b1;
            end
        end
    endtask

    task automatic do_start(input logic [2:0] tsc, input logic [1:0] stl, input bit with_edge,
                            input string tag);
        pay_idx = 0;
        xfer_cnt = 0;
        done_cnt = 0;
        data_bit = pay[0];
        tsc_sel = tsc;
        steal_flags = stl;
        start = 1'b1;
        if (with_edge) symbol_input_strobe = 1'b1;
        tick();
        start = 1'b0;
        tsc_sel = ~tsc;
        steal_flags = ~stl;
        check({tag, " active0"}, 32'(act0), 32'd1);
        check({tag, " active1"}, 32'(act1), 32'd1);
        check({tag, " underrun0"}, 32'(und0), 32'd0);
        check({tag, " ready0"}, 32'(rdy0), 32'd1);
        check({tag, " sym0_start"}, 32'(sym0), 32'd1);
        check({tag, " sym1_start"}, 32'(sym1), 32'd1);
    endtask

    // Issue symbols first..last-1, strobe high for 'hold' cycles then low for one.
    task automatic run_syms(input int first, input int last, input int hold, input string tag);
        for (int i = first; i < last; i++) begin
            symbol_input_strobe = 1'b1;
            tick();
            check($sformatf("%s sym0[%0d]", tag, i), 32'(sym0), 32'(exp_raw[i]));
            check($sformatf("%s sym1[%0d]", tag, i), 32'(sym1), 32'(exp_dif[i]));
            if (i == NSYM - 2) check({tag, " done_early"}, 32'(done0), 32'd0);
            if (i == NSYM - 1) begin
                check({tag, " done_pulse0"}, 32'(done0), 32'd1);
                check({tag, " done_pulse1"}, 32'(done1), 32'd1);
                check({tag, " active_end"}, 32'(act0), 32'd0);
            end
            for (int h = 1; h < hold; h++) tick();
            symbol_input_strobe = 1'b0;
            tick();
        end
    endtask

    task automatic end_checks(input int exp_xfers, input string tag);
        check({tag, " accepted"}, 32'(xfer_cnt), 32'(exp_xfers));
        check({tag, " done_count"}, 32'(done_cnt), 32'd1);
        check({tag, " done_low"}, 32'(done0), 32'd0);
        check({tag, " state_idle"}, 32'(st0), 32'd0);
        check({tag, " idle_sym0"}, 32'(sym0), 32'd1);
        check({tag, " idle_sym1"}, 32'(sym1), 32'd1);
        check({tag, " idle_ready"}, 32'(rdy0), 32'd0);
    endtask

    initial begin
        tsc_tab[0] = 26'b00100101110000100010010111;
        tsc_tab[1] = 26'b00101101110111100010110111;
        tsc_tab[2] = 26'b01000011101110100100001110;
        tsc_tab[3] = 26'b01000111101101000100011110;
        tsc_tab[4] = 26'b00011010111001000001101011;
        tsc_tab[5] = 26'b01001110101100000100111010;
        tsc_tab[6] = 26'b10100111110110001010011111;
        tsc_tab[7] = 26'b11101111000100101110111100;
        pay_idx = 0; xfer_cnt = 0; done_cnt = 0;
        reset = 1'b1; start = 1'b0; tsc_sel = 3'd0; steal_flags = 2'd0;
        data_bit = 1'b0; data_valid = 1'b0; symbol_input_strobe = 1'b0;

        // Reset values.
        tick(); tick();
        check("rst sym0", 32'(sym0), 32'd1);
        check("rst sym1", 32'(sym1), 32'd1);
        check("rst active", 32'(act0), 32'd0);
        check("rst ready", 32'(rdy0), 32'd0);
        check("rst done", 32'(done0), 32'd0);
        check("rst underrun", 32'(und0), 32'd0);
        check("rst state", 32'(st0), 32'd0);
        reset = 1'b0;
        tick();

        // Plain burst, TSC0, no stealing, all-zero payload.
        for (int k = 0; k < 114; k++) pay[k] = 1'b0;
        data_valid = 1'b1;
        build_model(3'd0, 2'b00, 1'b0);
        do_start(3'd0, 2'b00, 1'b0, "zero");
        run_syms(0, NSYM, 1, "zero");
        end_checks(114, "zero");

        // Strobe edge in IDLE is ignored.
        symbol_input_strobe = 1'b1; tick();
        symbol_input_strobe = 1'b0; tick();
        check("idle_edge sym0", 32'(sym0), 32'd1);
        check("idle_edge active", 32'(act0), 32'd0);

        // All-one payload with both stealing bits: differential stream 1,0,0,1,0...
        for (int k = 0; k < 114; k++) pay[k] = 1'b1;
        build_model(3'd0, 2'b11, 1'b0);
        do_start(3'd0, 2'b11, 1'b0, "ones");
        run_syms(0, NSYM, 1, "ones");
        end_checks(114, "ones");

        // Random payload, TSC5, first stealing bit only.
        for (int k = 0; k < 114; k++) pay[k] = 1'($urandom_range(0, 1));
        build_model(3'd5, 2'b10, 1'b0);
        do_start(3'd5, 2'b10, 1'b0, "rand");
        run_syms(0, NSYM, 1, "rand");
        end_checks(114, "rand");

        // Starved payload: underrun on the first DATA1 slot, burst still completes.
        data_valid = 1'b0;
        build_model(3'd1, 2'b01, 1'b1);
        do_start(3'd1, 2'b01, 1'b0, "starve");
        run_syms(0, 3, 1, "starve");
        check("starve und_before", 32'(und0), 32'd0);
        run_syms(3, 4, 1, "starve");
        check("starve und_after0", 32'(und0), 32'd1);
        check("starve und_after1", 32'(und1), 32'd1);
        run_syms(4, NSYM, 1, "starve");
        end_checks(0, "starve");
        check("starve und_sticky", 32'(und0), 32'd1);

        // Mid-burst start is ignored; reset at symbol 70 aborts the burst.
        data_valid = 1'b1;
        for (int k = 0; k < 114; k++) pay[k] = 1'($urandom_range(0, 1));
        build_model(3'd2, 2'b01, 1'b0);
        do_start(3'd2, 2'b01, 1'b0, "abort");
        check("abort und_cleared", 32'(und1), 32'd0);
        run_syms(0, 30, 1, "abort");
        start = 1'b1; tsc_sel = 3'd7; steal_flags = 2'b10;
        tick();
        start = 1'b0;
        run_syms(30, 70, 1, "abort");
        reset = 1'b1;
        tick();
        check("abort sym0", 32'(sym0), 32'd1);
        check("abort sym1", 32'(sym1), 32'd1);
        check("abort active", 32'(act0), 32'd0);
        check("abort ready", 32'(rdy0), 32'd0);
        check("abort state", 32'(st1), 32'd0);
        check("abort done_count", 32'(done_cnt), 32'd0);
        reset = 1'b0;
        tick();

        // Full burst right after the abort.
        build_model(3'd7, 2'b10, 1'b0);
        do_start(3'd7, 2'b10, 1'b0, "after");
        run_syms(0, NSYM, 1, "after");
        end_checks(114, "after");

        // Start coincident with an edge, strobe held high 5 cycles per symbol.
        for (int k = 0; k < 114; k++) pay[k] = 1'($urandom_range(0, 1));
        build_model(3'd3, 2'b01, 1'b0);
        do_start(3'd3, 2'b01, 1'b1, "hold");
        for (int h = 1; h < 5; h++) tick();
        check("hold no_consume", 32'(sym0), 32'd1);
        symbol_input_strobe = 1'b0;
        tick();
        run_syms(0, NSYM, 5, "hold");
        end_checks(114, "hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
